ama_riscv_perf_monitor: RTL
===========================

# ama_riscv_perf_monitor

Testbench-side performance monitor and retirement trace buffer that sits directly downstream of the core view. It consumes the writeback-stage trace signals produced there: retired inst/PC, branch, branch predictor, dmem, bubble and tohost. It accumulates saturating event counters, freezes them when the program signals completion through tohost, and queues one record per retired instruction in a ring FIFO. The bench drains that FIFO with a valid/ready handshake.

## Interface
- CNT_W, 64, width of every event counter
- TRACE_DEPTH, 16, trace FIFO entries; power of 2, at least 2
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- clear  in  1  synchronous soft clear: counters, drop count, FIFO and state to reset values
- inst_retired  in  1  an instruction retires this cycle
- inst_wbk  in  INST_WIDTH  retired instruction, zero when not retired
- pc_wbk  in  ARCH_WIDTH  retired PC, zero when not retired
- branch_inst_wbk  in  1  retired instruction is a branch
- branch_taken_wbk  in  1  retired branch was taken
- bp_hit_wbk  in  1  predictor was correct for the retired branch
- dmem_size_wbk  in  4  0-3 = lb/lh/lw/ld, 4-7 = sb/sh/sw/sd, 8 = no access
- dmem_addr_wbk  in  ARCH_WIDTH  dmem address, zero when no access
- bubble_wbk  in  1  writeback slot holds a bubble
- csr_tohost_wbk  in  ARCH_WIDTH  tohost value at writeback
- dc_stalled  in  1  data cache stall this cycle
- state  out  2  perf_state_t: IDLE, RUN, DONE
- cnt_cycles, cnt_retired, cnt_bubble, cnt_branch, cnt_taken, cnt_bp_miss, cnt_load, cnt_store, cnt_dc_stall  out  CNT_W each  event counters
- trace_valid  out  1  FIFO head record available
- trace_ready  in  1  consumer accepts head
- trace_rec  out  trace_rec_t  {pc, inst, dmem_addr, dmem_size, branch, taken}
- trace_drops  out  CNT_W  records dropped because the FIFO was full

## Operation
- **Reset values.** On rst (async) or clear: state = IDLE, all counters = 0, trace_drops = 0, FIFO empty, trace_valid = 0.
- **IDLE.** Counters hold. On inst_retired = 1 the state goes to RUN, and that same cycle is counted in full: cycles, retired, and its events.
- **RUN.** In every cycle:
  - cnt_cycles increments.
  - cnt_bubble increments when bubble_wbk = 1.
  - cnt_dc_stall increments when dc_stalled = 1.
- **RUN, when inst_retired = 1:**
  - cnt_retired increments.
  - cnt_branch increments when branch_inst_wbk = 1.
  - cnt_taken increments when branch_inst_wbk and branch_taken_wbk are both 1.
  - cnt_bp_miss increments when branch_inst_wbk = 1 and bp_hit_wbk = 0.
  - cnt_load increments when dmem_size_wbk < 4; cnt_store increments when dmem_size_wbk is 4 to 7. A value of 8 or above counts as neither.
- **Event qualification.** Event inputs are ignored when inst_retired = 0, except bubble and dc_stalled.
- **Entering DONE.** In RUN, csr_tohost_wbk != 0 moves the state to DONE. The current cycle's events are still counted. If tohost is non-zero in the IDLE→RUN cycle, the state goes straight to DONE, still counting that cycle.
- **DONE.** Counters and trace_drops are frozen. No pushes. The FIFO keeps draining. Only rst or clear leaves DONE.
- **Counter arithmetic.** All counters are unsigned and saturate at 2^CNT_W−1; they never wrap.
- **Trace push.** A record is pushed on inst_retired in the IDLE→RUN cycle and in RUN cycles.
- **Trace pop.** A pop happens when trace_valid && trace_ready.
- **Push while full.** If the FIFO is full and no pop occurs that cycle, the record is dropped and trace_drops increments (saturating). If full with a pop in the same cycle, the push is accepted and the occupancy stays at TRACE_DEPTH.
- **Pointers.** Pointers are log2(TRACE_DEPTH)+1 bits. Full and empty are decided by the MSB compare; the pointers wrap naturally.
- **Output stability.** trace_rec is stable while trace_valid && !trace_ready.
- **Clear precedence.** clear overrides any simultaneous push, pop or retire.

## Timing
- Counters are registered and show an event one cycle after the cycle in which it occurs.
- state updates on the clock edge after the triggering cycle.
- A pushed record first shows as trace_valid on the cycle after the push. trace_rec is driven straight from FIFO storage at the read pointer.
- Pop throughput is one record per cycle. Sustained push and pop at the same rate never drops.
- rst mid-operation discards FIFO contents immediately (async) and zeroes trace_valid in the same cycle.

## Structure
- Shared TB package holds:
  - perf_state_t enum
  - trace_rec_t packed struct
  - DMEM_SIZE_NA = 8
  - DMEM_FIRST_STORE = 4
- One sub-module, ama_riscv_trace_fifo: parameterized synchronous FIFO of trace_rec_t with push/pop, full, empty and async reset. Its push is not blocked when full only if a pop happens that cycle.
- Counters are a generate loop over a saturating-increment helper function.

## Test plan
- **Basic counting.** Reset, then retire 5 ALU instructions back-to-back. Expect state RUN; cnt_retired = 5 and cnt_cycles = 5 one cycle after the last retire; trace_valid = 1 with the first pc.
- **Branch and dmem mix.** Retire 3 branches (2 taken; bp_hit = 0 on one), 2 lw (size 2) and 1 sb (size 4). Expect cnt_branch = 3, cnt_taken = 2, cnt_bp_miss = 1, cnt_load = 2, cnt_store = 1.
- **FIFO overflow.** With TRACE_DEPTH = 16 and trace_ready = 0, retire 20 instructions. Expect 16 records held and trace_drops = 4. Then hold trace_ready = 1 and push 1/pop 1 per cycle for 10 cycles: expect no new drops.
- **tohost freeze.** csr_tohost_wbk = 1 coincides with a retire. Expect that retire counted, then DONE; further retires leave counters unchanged while the FIFO still drains to empty.
- **Async reset mid-run.** Assert rst with 7 records queued. Expect trace_valid = 0 immediately, counters = 0, state = IDLE.
- **clear collision.** Pulse clear in the same cycle as a retire and a pop. Expect everything zero and the FIFO empty next cycle.

Source files
------------

// File: rtl/ama_riscv_perf_monitor_pkg.sv
// Shared types and constants for the perf monitor: FSM state, trace record
// layout, dmem size encodings and event-counter slot indices.
package ama_riscv_perf_monitor_pkg;

  localparam int INST_WIDTH = 32;
  localparam int ARCH_WIDTH = 64;

  localparam logic [3:0] DMEM_SIZE_NA     = 4'd8;
  localparam logic [3:0] DMEM_FIRST_STORE = 4'd4;

  localparam int CNT_CYCLES   = 0;
  localparam int CNT_RETIRED  = 1;
  localparam int CNT_BUBBLE   = 2;
  localparam int CNT_BRANCH   = 3;
  localparam int CNT_TAKEN    = 4;
  localparam int CNT_BP_MISS  = 5;
  localparam int CNT_LOAD     = 6;
  localparam int CNT_STORE    = 7;
  localparam int CNT_DC_STALL = 8;
  localparam int CNT_DROPS    = 9;
  localparam int NUM_CNT      = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perf_state_t;

  typedef struct packed {
    logic [ARCH_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
    logic [ARCH_WIDTH-1:0] dmem_addr;
    logic [3:0]            dmem_size;
    logic                  branch;
    logic                  taken;
  } trace_rec_t;

endpackage

// File: rtl/ama_riscv_perf_monitor_if.sv
// Bundle of writeback trace inputs, counter outputs and the trace drain port.
// slave = the monitor's view, master = the driving/draining bench's view.
interface ama_riscv_perf_monitor_if #(
  parameter int CNT_W = 64
);
  import ama_riscv_perf_monitor_pkg::*;

  logic                  clear;
  logic                  inst_retired;
  logic [INST_WIDTH-1:0] inst_wbk;
  logic [ARCH_WIDTH-1:0] pc_wbk;
  logic                  branch_inst_wbk;
  logic                  branch_taken_wbk;
  logic                  bp_hit_wbk;
  logic [3:0]            dmem_size_wbk;
  logic [ARCH_WIDTH-1:0] dmem_addr_wbk;
  logic                  bubble_wbk;
  logic [ARCH_WIDTH-1:0] csr_tohost_wbk;
  logic                  dc_stalled;

  perf_state_t           state;
  logic [CNT_W-1:0]      cnt_cycles;
  logic [CNT_W-1:0]      cnt_retired;
  logic [CNT_W-1:0]      cnt_bubble;
  logic [CNT_W-1:0]      cnt_branch;
  logic [CNT_W-1:0]      cnt_taken;
  logic [CNT_W-1:0]      cnt_bp_miss;
  logic [CNT_W-1:0]      cnt_load;
  logic [CNT_W-1:0]      cnt_store;
  logic [CNT_W-1:0]      cnt_dc_stall;

  logic                  trace_valid;
  logic                  trace_ready;
  trace_rec_t            trace_rec;
  logic [CNT_W-1:0]      trace_drops;

  modport slave (
    input  clear, inst_retired, inst_wbk, pc_wbk, branch_inst_wbk,
           branch_taken_wbk, bp_hit_wbk, dmem_size_wbk, dmem_addr_wbk,
           bubble_wbk, csr_tohost_wbk, dc_stalled, trace_ready,
    output state, cnt_cycles, cnt_retired, cnt_bubble, cnt_branch, cnt_taken,
           cnt_bp_miss, cnt_load, cnt_store, cnt_dc_stall,
           trace_valid, trace_rec, trace_drops
  );

  modport master (
    output clear, inst_retired, inst_wbk, pc_wbk, branch_inst_wbk,
           branch_taken_wbk, bp_hit_wbk, dmem_size_wbk, dmem_addr_wbk,
           bubble_wbk, csr_tohost_wbk, dc_stalled, trace_ready,
    input  state, cnt_cycles, cnt_retired, cnt_bubble, cnt_branch, cnt_taken,
           cnt_bp_miss, cnt_load, cnt_store, cnt_dc_stall,
           trace_valid, trace_rec, trace_drops
  );

endinterface

// File: rtl/ama_riscv_trace_fifo.sv
// Ring FIFO of trace records with extra-MSB pointers; a push while full is
// accepted only when a pop frees the head slot in the same cycle.
module ama_riscv_trace_fifo
  import ama_riscv_perf_monitor_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic       i_pop,
  input  trace_rec_t i_rec,
  output trace_rec_t o_rec,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  trace_rec_t  r_mem [DEPTH];
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);
  assign o_rec   = r_mem[r_rd_ptr[AW-1:0]];

  // Read/write pointers; clear wins over any same-cycle push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Record storage
  always_ff @(posedge clk) begin
    if (w_wr_en && !i_clear) r_mem[r_wr_ptr[AW-1:0]] <= i_rec;
  end

endmodule

// File: rtl/ama_riscv_perf_monitor.sv
// Writeback-stage performance monitor: saturating event counters frozen on
// tohost, plus a trace FIFO of retired instructions drained by valid/ready.
module ama_riscv_perf_monitor #(
  parameter int CNT_W       = 64,
  parameter int TRACE_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ama_riscv_perf_monitor_if.slave bus
);
  import ama_riscv_perf_monitor_pkg::*;

  perf_state_t                   r_state;
  perf_state_t                   w_state_nxt;
  logic                          w_count_en;
  logic                          w_tohost_hit;
  logic                          w_is_load;
  logic                          w_is_store;
  logic                          w_retire_cnt;
  logic                          w_push_req;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_drop;
  logic [NUM_CNT-1:0]            w_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] w_cnt;
  trace_rec_t                    w_rec_in;
  trace_rec_t                    w_rec_out;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The IDLE->RUN retire cycle counts like a RUN cycle; DONE freezes everything
  assign w_count_en   = (r_state == RUN) || ((r_state == IDLE) && bus.inst_retired);
  assign w_retire_cnt = w_count_en && bus.inst_retired;
  assign w_tohost_hit = (bus.csr_tohost_wbk != {ARCH_WIDTH{1'b0}});
  assign w_is_load    = (bus.dmem_size_wbk < DMEM_FIRST_STORE);
  assign w_is_store   = (bus.dmem_size_wbk >= DMEM_FIRST_STORE) &&
                        (bus.dmem_size_wbk < DMEM_SIZE_NA);
  assign w_push_req   = w_retire_cnt;
  assign w_pop        = !w_empty && bus.trace_ready;
  assign w_drop       = w_push_req && w_full && !w_pop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (bus.clear) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.inst_retired) w_state_nxt = w_tohost_hit ? DONE : RUN;
        else                  w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_tohost_hit) w_state_nxt = DONE;
        else              w_state_nxt = RUN;
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-counter increment enables
  always_comb begin
    w_inc               = {NUM_CNT{1'b0}};
    w_inc[CNT_CYCLES]   = w_count_en;
    w_inc[CNT_BUBBLE]   = w_count_en && bus.bubble_wbk;
    w_inc[CNT_DC_STALL] = w_count_en && bus.dc_stalled;
    w_inc[CNT_RETIRED]  = w_retire_cnt;
    w_inc[CNT_BRANCH]   = w_retire_cnt && bus.branch_inst_wbk;
    w_inc[CNT_TAKEN]    = w_retire_cnt && bus.branch_inst_wbk && bus.branch_taken_wbk;
    w_inc[CNT_BP_MISS]  = w_retire_cnt && bus.branch_inst_wbk && !bus.bp_hit_wbk;
    w_inc[CNT_LOAD]     = w_retire_cnt && w_is_load;
    w_inc[CNT_STORE]    = w_retire_cnt && w_is_store;
    w_inc[CNT_DROPS]    = w_drop;
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gen_cnt
    logic [CNT_W-1:0] r_cnt;

    // One saturating event counter
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (bus.clear) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_inc[g]) begin
        r_cnt <= sat_inc(r_cnt);
      end
    end

    assign w_cnt[g] = r_cnt;
  end

  assign w_rec_in.pc        = bus.pc_wbk;
  assign w_rec_in.inst      = bus.inst_wbk;
  assign w_rec_in.dmem_addr = bus.dmem_addr_wbk;
  assign w_rec_in.dmem_size = bus.dmem_size_wbk;
  assign w_rec_in.branch    = bus.branch_inst_wbk;
  assign w_rec_in.taken     = bus.branch_taken_wbk;

  ama_riscv_trace_fifo #(
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_rec   (w_rec_in),
    .o_rec   (w_rec_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.state        = r_state;
  assign bus.cnt_cycles   = w_cnt[CNT_CYCLES];
  assign bus.cnt_retired  = w_cnt[CNT_RETIRED];
  assign bus.cnt_bubble   = w_cnt[CNT_BUBBLE];
  assign bus.cnt_branch   = w_cnt[CNT_BRANCH];
  assign bus.cnt_taken    = w_cnt[CNT_TAKEN];
  assign bus.cnt_bp_miss  = w_cnt[CNT_BP_MISS];
  assign bus.cnt_load     = w_cnt[CNT_LOAD];
  assign bus.cnt_store    = w_cnt[CNT_STORE];
  assign bus.cnt_dc_stall = w_cnt[CNT_DC_STALL];
  assign bus.trace_drops  = w_cnt[CNT_DROPS];
  assign bus.trace_valid  = !w_empty;
  assign bus.trace_rec    = w_rec_out;

endmodule
